// File: rtl/wb_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// wb_stage_pipe_if
// Bundles the MEM-stage capture inputs and the writeback / forwarding /
// retire outputs of the writeback stage.
//   master : MEM-stage side (drives en/flush/*_in, observes results)
//   slave  : writeback stage (captures *_in, drives grf_*, fwd_*, retire_cnt)
// Parameters must match the wb_stage_pipe instance the interface is bound to.
// ---------------------------------------------------------------------------
interface wb_stage_pipe_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              en;
  logic              flush;
  logic [31:0]       instr_in;
  logic [31:0]       pc8_in;
  logic [31:0]       alu_in;
  logic [31:0]       dm_in;
  logic [REG_AW-1:0] wreg_in;

  logic [REG_AW-1:0] grf_a3;
  logic              grf_we;
  logic [31:0]       grf_wd;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [31:0]       fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output en, flush, instr_in, pc8_in, alu_in, dm_in, wreg_in,
    input  grf_a3, grf_we, grf_wd, fwd_valid, fwd_addr, fwd_data, retire_cnt
  );

  modport slave (
    input  en, flush, instr_in, pc8_in, alu_in, dm_in, wreg_in,
    output grf_a3, grf_we, grf_wd, fwd_valid, fwd_addr, fwd_data, retire_cnt
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// ---------------------------------------------------------------------------
// wb_stage_pipe
// MIPS writeback stage: MEM/WB pipeline register with stall/flush, writeback
// class decode, load sub-word extraction, GRF write port, registered
// forwarding tap and a retired-instruction counter.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears every pipeline register
//   bus    : wb_stage_pipe_if.slave
//            en/flush       capture control (flush overrides en)
//            *_in           MEM-stage instruction fields
//            grf_a3/we/wd   GRF write port
//            fwd_*          forwarding tap (zero when FWD_EN == 0)
//            retire_cnt     non-bubble instructions retired (wraps)
//
// All outputs are decoded from the registered fields only, so there is no
// combinational path from the MEM-stage inputs to the GRF port.
// ---------------------------------------------------------------------------
module wb_stage_pipe #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  wb_stage_pipe_if.slave   bus
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LOAD = 2'd2,
    CLS_LINK = 2'd3
  } wb_class_e;

  // MEM/WB pipeline register
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc8_q,   pc8_d;
  logic [31:0]       alu_q,   alu_d;
  logic [31:0]       dm_q,    dm_d;
  logic [REG_AW-1:0] wreg_q,  wreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      pc8_q   <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      wreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      wreg_q  <= wreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // flush beats en; a bubble is all-zero fields so it decodes as a nop.
  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    alu_d   = alu_q;
    dm_d    = dm_q;
    wreg_d  = wreg_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      instr_d = '0;
      pc8_d   = '0;
      alu_d   = '0;
      dm_d    = '0;
      wreg_d  = '0;
    end else if (bus.en) begin
      instr_d = bus.instr_in;
      pc8_d   = bus.pc8_in;
      alu_d   = bus.alu_in;
      dm_d    = bus.dm_in;
      wreg_d  = bus.wreg_in;
      if (bus.instr_in != 32'd0) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Writeback class decode
  logic [5:0] opcode;
  logic [5:0] funct;
  wb_class_e  wb_class;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];

  always_comb begin
    wb_class = CLS_NONE;
    unique case (opcode)
      OP_ORI, OP_XORI, OP_ANDI, OP_SLTI, OP_SLTIU,
      OP_ADDI, OP_ADDIU, OP_LUI:                  wb_class = CLS_ALU;
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:        wb_class = CLS_LOAD;
      OP_JAL:                                     wb_class = CLS_LINK;
      OP_SPECIAL: begin
        unique case (funct)
          // all-zero word is the canonical nop, not "sll $0,$0,0" writeback
          FN_SLL:  wb_class = (instr_q != 32'd0) ? CLS_ALU : CLS_NONE;
          FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:                        wb_class = CLS_ALU;
          FN_JALR:                                wb_class = CLS_LINK;
          default:                                wb_class = CLS_NONE;
        endcase
      end
      default:                                    wb_class = CLS_NONE;
    endcase
  end

  // Load sub-word extraction from the aligned DM word (little-endian lanes)
  logic [1:0]  ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_off = alu_q[1:0];

  always_comb begin
    ld_byte = dm_q[7:0];
    unique case (ld_off)
      2'd0: ld_byte = dm_q[7:0];
      2'd1: ld_byte = dm_q[15:8];
      2'd2: ld_byte = dm_q[23:16];
      2'd3: ld_byte = dm_q[31:24];
      default: ld_byte = dm_q[7:0];
    endcase
  end

  // Halfword lane chosen by off[1] only; a misaligned off[0] is ignored.
  assign ld_half = ld_off[1] ? dm_q[31:16] : dm_q[15:0];

  always_comb begin
    ld_data = dm_q;
    unique case (opcode)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = dm_q;
    endcase
  end

  // GRF write port
  logic        a3_zero;
  logic        we_raw;
  logic [31:0] wd_sel;

  assign a3_zero = (wreg_q == '0);
  assign we_raw  = (wb_class != CLS_NONE);

  always_comb begin
    wd_sel = 32'd0;
    unique case (wb_class)
      CLS_ALU:  wd_sel = alu_q;
      CLS_LOAD: wd_sel = ld_data;
      CLS_LINK: wd_sel = pc8_q;
      default:  wd_sel = 32'd0;
    endcase
  end

  // Writes to $0 are suppressed and report zero data so the forwarding
  // tap never offers a stale value for $0.
  assign bus.grf_a3 = wreg_q;
  assign bus.grf_we = we_raw && !a3_zero;
  assign bus.grf_wd = a3_zero ? 32'd0 : wd_sel;

  // Forwarding tap
  generate
    if (FWD_EN != 0) begin : g_fwd
      assign bus.fwd_valid = bus.grf_we;
      assign bus.fwd_addr  = bus.grf_a3;
      assign bus.fwd_data  = bus.grf_wd;
    end else begin : g_no_fwd
      assign bus.fwd_valid = 1'b0;
      assign bus.fwd_addr  = '0;
      assign bus.fwd_data  = 32'd0;
    end
  endgenerate

  assign bus.retire_cnt = cnt_q;

endmodule
